// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter with optional even parity bit
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   FIFO_DEPTH    transmit FIFO entries (power of two, 2..64)
// Ports:
//   i_clk         sole clock, rising edge
//   i_rst         synchronous active-high reset; aborts any frame and empties the FIFO
//   i_uart_valid  byte offered by the core this cycle
//   i_uart_data   byte offered by the core
//   o_uart_ready  FIFO has room; a byte is accepted when valid and ready are both high
//   o_uart_tx     registered serial line, idle high
//   o_uart_busy   a frame is in flight or bytes are still queued
//   o_fifo_count  current FIFO occupancy
// Build option:
//   UART_TX_PARITY_EN  adds an even-parity bit between the data bits and the stop bit
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_uart_valid,
    input  logic [7:0]                    i_uart_data,
    output logic                          o_uart_ready,
    output logic                          o_uart_tx,
    output logic                          o_uart_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          push, pop, tick, empty;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign o_uart_ready = count_q != FULL;
    assign push         = i_uart_valid && o_uart_ready;
    assign empty        = count_q == '0;
    assign tick         = baud_q == '0;
    assign count_d      = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    assign o_uart_tx    = tx_q;
    assign o_uart_busy  = state_q != IDLE || !empty;
    assign o_fifo_count = count_q;

    always_comb begin
        state_d = state_q;
        baud_d  = tick ? BAUD_MAX : baud_q - 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = empty ? 16'd0 : BAUD_MAX;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: if (tick) begin
                state_d = DATA;
                bit_d   = 3'd0;
                tx_d    = shift_q[0];
                shift_d = {1'b0, shift_q[7:1]};
            end
            DATA: if (tick) begin
                if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d    = par_q;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_d   = bit_q + 3'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
`endif
            STOP: if (tick) begin
                // Chain straight into the next start bit when more bytes are queued.
                pop     = !empty;
                state_d = empty ? IDLE : START;
                tx_d    = !empty ? 1'b0 : 1'b1;
                baud_d  = empty ? 16'd0 : BAUD_MAX;
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                baud_d  = 16'd0;
            end
        endcase
        shift_d = pop ? mem_q[rd_q] : shift_d;
    end

`ifdef UART_TX_PARITY_EN
    assign par_d = pop ? ^mem_q[rd_q] : par_q;
`endif

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_q] <= i_uart_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            wr_q    <= push ? wr_q + AW'(1) : wr_q;
            rd_q    <= pop ? rd_q + AW'(1) : rd_q;
            count_q <= count_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven check of uart_tx framing, FIFO flow control and reset
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready, tx, busy;
    logic [3:0] count;
    int         passed = 0;
    int         total  = 0;
    logic       saw_full = 1'b0;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_uart_valid(valid),
        .i_uart_data(data),
        .o_uart_ready(ready),
        .o_uart_tx(tx),
        .o_uart_busy(busy),
        .o_fifo_count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [9:0] f;
        logic       p;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        else passed++;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b01, d, 1'b0};
`endif
    endfunction

    task automatic check_frame(input logic [10:0] f, input string n);
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                chk(n, 32'({busy, tx}), 32'({1'b1, f[b]}));
            end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [10:0] ef;
        vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
        vecs[1] = '{8'h3C, 10'b1001111000, 1'b0};
        vecs[2] = '{8'h81, 10'b1100000010, 1'b0};
        vecs[3] = '{8'h07, 10'b1000001110, 1'b1};
        vecs[4] = '{8'h03, 10'b1000000110, 1'b0};
        vecs[5] = '{8'h01, 10'b1000000010, 1'b1};

        repeat (3) step;
        chk("rst_tx", tx, 1);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        step;
        chk("idle_state", {tx, ready, busy, count}, {1'b1, 1'b1, 1'b0, 4'd0});

        // single frames from the table
        foreach (vecs[i]) begin
`ifdef UART_TX_PARITY_EN
            ef = {1'b1, vecs[i].p, vecs[i].f[8:0]};
`else
            ef = {1'b0, vecs[i].f};
`endif
            chk("vec_ready", ready, 1);
            valid = 1'b1;
            data  = vecs[i].d;
            step;
            valid = 1'b0;
            chk("vec_accept", {tx, busy, count}, {1'b1, 1'b1, 4'd1});
            step;
            chk("vec_pop", {tx, count}, {1'b0, 4'd0});
            check_frame(ef, "vec_frame");
            @(negedge clk);
            chk("vec_done", {busy, tx}, 2'b01);
            step;
        end

        // back-to-back frames, no idle gap
        valid = 1'b1;
        data  = 8'h00;
        step;
        data  = 8'hFF;
        step;
        valid = 1'b0;
        chk("b2b_count", count, 1);
        check_frame(frame(8'h00), "b2b_frame0");
        check_frame(frame(8'hFF), "b2b_frame1");
        @(negedge clk);
        chk("b2b_done", busy, 0);
        step;

        // simultaneous push and pop at count 3
        valid = 1'b1;
        data  = 8'h11;
        step;
        data  = 8'h22;
        step;
        data  = 8'h33;
        step;
        data  = 8'h44;
        step;
        valid = 1'b0;
        chk("pp_count_pre", count, 3);
        repeat (NB * CPB - 3) step;
        chk("pp_count_stop", count, 3);
        valid = 1'b1;
        data  = 8'h55;
        step;
        valid = 1'b0;
        chk("pp_count", count, 3);
        chk("pp_start", tx, 0);
        check_frame(frame(8'h22), "pp_frame22");
        check_frame(frame(8'h33), "pp_frame33");
        check_frame(frame(8'h44), "pp_frame44");
        check_frame(frame(8'h55), "pp_frame55");
        @(negedge clk);
        chk("pp_done", busy, 0);
        step;

        // FIFO full: valid held across 10 bytes
        fork
            begin
                logic r;
                for (int i = 1; i <= 10; i++) begin
                    data  = 8'(i);
                    valid = 1'b1;
                    r     = 1'b0;
                    for (int k = 0; k < 500 && !r; k++) begin
                        r = ready;
                        if (count == 4'(DEPTH)) begin
                            chk("full_ready", ready, 0);
                            saw_full = 1'b1;
                        end
                        step;
                    end
                    if (!r) chk("full_accept_timeout", 0, 1);
                end
                valid = 1'b0;
            end
            begin
                step;
                step;
                for (int i = 1; i <= 10; i++) check_frame(frame(8'(i)), "full_frame");
            end
        join
        @(negedge clk);
        chk("full_done", busy, 0);
        chk("full_seen", saw_full, 1);
        step;

        // reset during data bit 3 with two bytes queued
        valid = 1'b1;
        data  = 8'h00;
        step;
        data  = 8'h55;
        step;
        data  = 8'hAA;
        step;
        valid = 1'b0;
        chk("mr_count", count, 2);
        repeat (15) step;
        chk("mr_pre_tx", {tx, busy}, 2'b01);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("mr_tx", tx, 1);
        chk("mr_count0", count, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ready", ready, 1);
        for (int i = 0; i < 100; i++) begin
            step;
            chk("mr_quiet", {tx, busy, count}, {1'b1, 1'b0, 4'd0});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..64.
REQ-003 SHALL have port i_clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port i_uart_valid, input, 1, core byte-valid (core uart_valid).
REQ-006 SHALL have port i_uart_data, input, 8, core byte (core uart_out_data).
REQ-007 SHALL have port o_uart_ready, output, 1, FIFO can accept a byte (drives core uart_ready).
REQ-008 SHALL have port o_uart_tx, output, 1, serial line, idle high, registered.
REQ-009 SHALL have port o_uart_busy, output, 1, FSM not IDLE or FIFO non-empty.
REQ-010 SHALL have port o_fifo_count, output, clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-011 SHALL accept a byte on every rising edge where i_uart_valid=1 and o_uart_ready=1; no other edge writes the FIFO.
REQ-012 SHALL drive o_uart_ready = (o_fifo_count != FIFO_DEPTH), independent of same-cycle pops; no write when full, input ignored.
REQ-013 SHALL drop no accepted byte and SHALL transmit bytes in acceptance order.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY, see REQ-024).
REQ-015 SHALL, in IDLE with FIFO non-empty, pop the head byte into a shift register and enter START on the same edge; o_uart_tx low from that edge.
REQ-016 SHALL hold each bit exactly CLKS_PER_BIT cycles via down-counter reloaded at each bit boundary.
REQ-017 SHALL send START=0, then 8 data bits LSB first, then STOP=1; frame = 10*CLKS_PER_BIT cycles.
REQ-018 SHALL, at end of STOP with FIFO non-empty, pop and enter START directly (no idle gap); else enter IDLE.
REQ-019 SHALL produce first falling edge of o_uart_tx exactly 2 edges after acceptance when idle and empty (edge E write, edge E+1 pop/START).
REQ-020 SHALL update o_fifo_count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop; pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL accept a push in the same cycle as a pop when count < FIFO_DEPTH, including from empty-to-pop cases never occurring (pop requires non-empty).

Reset
REQ-022 SHALL, on i_rst=1 at a rising edge, clear FIFO pointers and count, set FSM to IDLE, bit counter and baud counter to 0, o_uart_tx=1, o_uart_ready=1, o_uart_busy=0, o_fifo_count=0.
REQ-023 SHALL, on reset mid-frame, abort the frame; o_uart_tx high from that edge; FIFO contents discarded; no partial byte resumed.

Configuration
REQ-024 SHALL, when macro UART_TX_PARITY_EN is defined, insert a PARITY state between DATA and STOP sending even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT.
REQ-025 SHALL, without UART_TX_PARITY_EN, contain no PARITY state or parity logic; DATA goes directly to STOP; frame = 10*CLKS_PER_BIT.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8 unless stated)
REQ-026 SHALL cover single byte: push 0xA5 at edge E idle -> tx low at E+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, high stop 4 cycles, busy=0 at frame end.
REQ-027 SHALL cover back-to-back: push 0x00,0xFF consecutively -> two frames, total 80 cycles, no idle-high gap between stop bit and second start bit.
REQ-028 SHALL cover full: valid held with 10 bytes 0x01..0x0A while transmitting -> ready=0 once count=8, bytes beyond acceptance stall, all received in order 0x01..0x0A by serial monitor.
REQ-029 SHALL cover simultaneous push/pop: count=3, push on pop edge -> count stays 3.
REQ-030 SHALL cover reset mid-frame: i_rst=1 during DATA bit 3 with 2 queued -> next edge tx=1, count=0, busy=0; no further frames.
REQ-031 SHALL cover parity build (UART_TX_PARITY_EN): 0x07 -> parity bit 1, frame 44 cycles; 0x03 -> parity bit 0.
